// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Included by the ring storage and the queue controller.
package fetch_queue_pkg;

  localparam int unsigned FQ_XLEN    = 64;
  localparam int unsigned FQ_ILEN    = 32;
  localparam int unsigned INST_BYTES = 4;

  // An all-zero instruction word stops the fetcher once it has been enqueued.
  localparam logic [31:0] INST_HALT = 32'h0;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_ILEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } fq_state_t;

endpackage

// File: rtl/fetch_queue_ring.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fq_ring
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks the PC, buffers {pc, inst} pairs for ID,
// and handles EX redirects, halt instructions and misaligned targets.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          entry,
  output logic [XLEN-1:0]          fetch_pc,
  input  logic                     fetch_ready,
  input  logic [ILEN-1:0]          fetch_inst,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [ILEN-1:0]          out_inst,
  input  logic                     out_take,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted,
  output logic                     misalign
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  fq_state_t       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic   full;
  logic   deq;
  logic   enq;
  logic   halt_inst;
  entry_t wr_entry;
  entry_t rd_entry;

  // Handshakes: an entry moves to ID when out_take && out_valid in the same
  // cycle; the icache word is consumed when enq is high, never otherwise.
  always_comb begin : handshake
    full      = (count_q == CW'(DEPTH));
    deq       = out_take && (count_q != '0);
    halt_inst = (fetch_inst == ILEN'(INST_HALT));
    enq       = fetch_ready && (state_q == RUN) && !redirect_valid && (!full || deq);
  end

  always_comb begin : fsm_next
    state_d = state_q;
    if (redirect_valid) begin
      // ERR is only left through reset, so an aligned redirect keeps it.
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ERR;
      end else if (state_q == HALT) begin
        state_d = RUN;
      end
    end else if (enq && halt_inst) begin
      state_d = HALT;
    end
  end

  always_comb begin : datapath_next
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (enq) begin
        tail_d     = tail_q + 1'b1;
        fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      end
      if (deq) begin
        head_d = head_q + 1'b1;
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= entry;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  assign wr_entry = '{pc: fetch_pc_q, inst: fetch_inst};

  fq_ring #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ring (
    .clk_i   (clk),
    .we_i    (enq && !reset),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (rd_entry)
  );

  assign fetch_pc  = fetch_pc_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = rd_entry.pc;
  assign out_inst  = rd_entry.inst;
  assign halted    = (state_q == HALT);
  assign misalign  = (state_q == ERR);

endmodule
